speicher_anbindung: RTL and testbench



---
 rtl/speicher_anbindung.sv | 144 ++++++++++++++
 tb/tb_speicher_anbindung.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_anbindung.sv
// Memory-side responder: serialises fetch/load/store requests onto a single-port
// request/ready memory bus and answers each with a one-cycle completion pulse.
module speicher_anbindung #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  LoadBefehlSignal,
  input  logic [ADDR_WIDTH-1:0] BefehlAdresse,
  input  logic                  LoadDatenSignal,
  input  logic                  StoreDatenSignal,
  input  logic [ADDR_WIDTH-1:0] DatenAdresse,
  input  logic [DATA_WIDTH-1:0] StoreDaten,
  output logic                  BefehlGeladen,
  output logic [DATA_WIDTH-1:0] Befehl,
  output logic                  DatenGeladen,
  output logic [DATA_WIDTH-1:0] GeladeneDaten,
  output logic                  DatenGespeichert,
  output logic                  Fehler,
  output logic                  MemAnfrage,
  output logic                  MemSchreiben,
  output logic [ADDR_WIDTH-1:0] MemAdresse,
  output logic [DATA_WIDTH-1:0] MemSchreibDaten,
  input  logic [DATA_WIDTH-1:0] MemLeseDaten,
  input  logic                  MemBereit,
  output logic [1:0]            zustand_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ANFRAGE = 2'd1,
    FERTIG  = 2'd2
  } zustand_t;

  typedef enum logic [1:0] {
    BEFEHL    = 2'd0,
    LADEN     = 2'd1,
    SPEICHERN = 2'd2
  } art_t;

  zustand_t              zustand_q, zustand_d;
  art_t                  art_q, art_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] sdaten_q, sdaten_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] befehl_q, befehl_d;
  logic [DATA_WIDTH-1:0] geladen_q, geladen_d;
  logic                  fehler_q, fehler_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q <= IDLE;
      art_q     <= BEFEHL;
      adr_q     <= '0;
      sdaten_q  <= '0;
      cnt_q     <= '0;
      befehl_q  <= '0;
      geladen_q <= '0;
      fehler_q  <= 1'b0;
    end else begin
      zustand_q <= zustand_d;
      art_q     <= art_d;
      adr_q     <= adr_d;
      sdaten_q  <= sdaten_d;
      cnt_q     <= cnt_d;
      befehl_q  <= befehl_d;
      geladen_q <= geladen_d;
      fehler_q  <= fehler_d;
    end
  end

  always_comb begin
    zustand_d = zustand_q;
    art_d     = art_q;
    adr_d     = adr_q;
    sdaten_d  = sdaten_q;
    cnt_d     = cnt_q;
    befehl_d  = befehl_q;
    geladen_d = geladen_q;
    fehler_d  = fehler_q;
    case (zustand_q)
      IDLE: begin
        // Store beats load beats fetch.
        if (StoreDatenSignal) begin
          art_d     = SPEICHERN;
          adr_d     = DatenAdresse;
          sdaten_d  = StoreDaten;
          cnt_d     = '0;
          zustand_d = ANFRAGE;
        end else if (LoadDatenSignal) begin
          art_d     = LADEN;
          adr_d     = DatenAdresse;
          cnt_d     = '0;
          zustand_d = ANFRAGE;
        end else if (LoadBefehlSignal) begin
          art_d     = BEFEHL;
          adr_d     = BefehlAdresse;
          cnt_d     = '0;
          zustand_d = ANFRAGE;
        end
      end
      ANFRAGE: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (MemBereit) begin
          if (art_q == BEFEHL) befehl_d = MemLeseDaten;
          else if (art_q == LADEN) geladen_d = MemLeseDaten;
          zustand_d = FERTIG;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          if (art_q == BEFEHL) befehl_d = '0;
          else if (art_q == LADEN) geladen_d = '0;
          fehler_d  = 1'b1;
          zustand_d = FERTIG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FERTIG: begin
        zustand_d = IDLE;
      end
      default: begin
        zustand_d = IDLE;
      end
    endcase
  end

  assign MemAnfrage       = (zustand_q == ANFRAGE);
  assign MemSchreiben     = (zustand_q == ANFRAGE) && (art_q == SPEICHERN);
  assign MemAdresse       = adr_q;
  assign MemSchreibDaten  = sdaten_q;
  assign BefehlGeladen    = (zustand_q == FERTIG) && (art_q == BEFEHL);
  assign DatenGeladen     = (zustand_q == FERTIG) && (art_q == LADEN);
  assign DatenGespeichert = (zustand_q == FERTIG) && (art_q == SPEICHERN);
  assign Befehl           = befehl_q;
  assign GeladeneDaten    = geladen_q;
  assign Fehler           = fehler_q;
  assign zustand_o        = zustand_q;

endmodule

// File: tb/tb_speicher_anbindung.sv
// Directed bench for speicher_anbindung: cycle-exact transactions against a
// scoreboard of expected completions plus reset and timeout corner cases.
module tb_speicher_anbindung;

  localparam int TO = 4;
  localparam int EW = 35;  // {kind[1:0], data[31:0], fehler}
  localparam logic [1:0] K_BEFEHL    = 2'd0;
  localparam logic [1:0] K_LADEN     = 2'd1;
  localparam logic [1:0] K_SPEICHERN = 2'd2;
  localparam logic [1:0] ST_IDLE     = 2'd0;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal;
  logic [31:0] BefehlAdresse, DatenAdresse, StoreDaten;
  logic        BefehlGeladen, DatenGeladen, DatenGespeichert, Fehler;
  logic [31:0] Befehl, GeladeneDaten;
  logic        MemAnfrage, MemSchreiben, MemBereit;
  logic [31:0] MemAdresse, MemSchreibDaten, MemLeseDaten;
  logic [1:0]  zustand_o;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_befehl, exp_geladen;
  logic          exp_fehler;

  speicher_anbindung #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .LoadBefehlSignal(LoadBefehlSignal), .BefehlAdresse(BefehlAdresse),
    .LoadDatenSignal(LoadDatenSignal), .StoreDatenSignal(StoreDatenSignal),
    .DatenAdresse(DatenAdresse), .StoreDaten(StoreDaten),
    .BefehlGeladen(BefehlGeladen), .Befehl(Befehl),
    .DatenGeladen(DatenGeladen), .GeladeneDaten(GeladeneDaten),
    .DatenGespeichert(DatenGespeichert), .Fehler(Fehler),
    .MemAnfrage(MemAnfrage), .MemSchreiben(MemSchreiben),
    .MemAdresse(MemAdresse), .MemSchreibDaten(MemSchreibDaten),
    .MemLeseDaten(MemLeseDaten), .MemBereit(MemBereit),
    .zustand_o(zustand_o)
  );

  // Clock and watchdog
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    chk1("rst_state_idle", zustand_o === ST_IDLE, 1'b1);
    chk1("rst_anfrage", MemAnfrage, 1'b0);
    chk1("rst_schreiben", MemSchreiben, 1'b0);
    chk32("rst_adresse", MemAdresse, 32'h0);
    chk32("rst_schreibdaten", MemSchreibDaten, 32'h0);
    chk1("rst_done_befehl", BefehlGeladen, 1'b0);
    chk1("rst_done_laden", DatenGeladen, 1'b0);
    chk1("rst_done_speichern", DatenGespeichert, 1'b0);
    chk32("rst_befehl", Befehl, 32'h0);
    chk32("rst_geladen", GeladeneDaten, 32'h0);
    chk1("rst_fehler", Fehler, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    LoadBefehlSignal = 1'b0;
    LoadDatenSignal  = 1'b0;
    StoreDatenSignal = 1'b0;
    MemBereit = 1'b0;
    tick();
    check_reset_state();
    Reset = 1'b0;
    exp_befehl  = '0;
    exp_geladen = '0;
    exp_fehler  = 1'b0;
    exp_q.delete();
  endtask

  // Pops the scoreboard entry for the completion visible in this cycle.
  task automatic check_done();
    logic [EW-1:0] e;
    logic [1:0]    k;
    string         t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      k = e[34:33];
      t = (k == K_BEFEHL) ? "done_data_befehl" : "done_data_geladen";
      chk1("done_befehl", BefehlGeladen, k == K_BEFEHL);
      chk1("done_laden", DatenGeladen, k == K_LADEN);
      chk1("done_speichern", DatenGespeichert, k == K_SPEICHERN);
      chk32(t, (k == K_BEFEHL) ? Befehl : GeladeneDaten, e[32:1]);
      chk1("done_fehler", Fehler, e[0]);
      chk1("done_anfrage_low", MemAnfrage, 1'b0);
    end
  endtask

  // One complete transaction starting in the current cycle. 'waits' is the
  // number of ANFRAGE cycles before MemBereit; 'to' leaves MemBereit low.
  task automatic run_txn(input logic [1:0] kind, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input bit to);
    int n;
    case (kind)
      K_BEFEHL:  begin LoadBefehlSignal = 1'b1; BefehlAdresse = addr; end
      K_LADEN:   begin LoadDatenSignal  = 1'b1; DatenAdresse  = addr; end
      default:   begin StoreDatenSignal = 1'b1; DatenAdresse  = addr; StoreDaten = wdata; end
    endcase
    if (kind == K_BEFEHL) exp_befehl = to ? 32'h0 : rdata;
    if (kind == K_LADEN) exp_geladen = to ? 32'h0 : rdata;
    exp_fehler = exp_fehler | to;
    exp_q.push_back({kind, (kind == K_BEFEHL) ? exp_befehl : exp_geladen, exp_fehler});
    n = to ? TO : waits + 1;
    for (int i = 1; i <= n; i++) begin
      tick();
      chk1("anfrage", MemAnfrage, 1'b1);
      chk1("schreiben", MemSchreiben, kind == K_SPEICHERN);
      chk32("adresse", MemAdresse, addr);
      if (kind == K_SPEICHERN) chk32("schreibdaten", MemSchreibDaten, wdata);
      if (!to && i == n) begin
        MemBereit = 1'b1;
        MemLeseDaten = rdata;
      end
    end
    tick();
    MemBereit = 1'b0;
    MemLeseDaten = $urandom;
    check_done();
    tick();
    case (kind)
      K_BEFEHL: LoadBefehlSignal = 1'b0;
      K_LADEN:  LoadDatenSignal  = 1'b0;
      default:  StoreDatenSignal = 1'b0;
    endcase
    chk1("idle_after_done", zustand_o === ST_IDLE, 1'b1);
    chk1("anfrage_idle", MemAnfrage, 1'b0);
    chk1("pulse_width", BefehlGeladen | DatenGeladen | DatenGespeichert, 1'b0);
    chk32("befehl_held", Befehl, exp_befehl);
    chk32("geladen_held", GeladeneDaten, exp_geladen);
  endtask

  initial begin
    logic [31:0] r;
    Reset = 1'b1;
    LoadBefehlSignal = 1'b0; LoadDatenSignal = 1'b0; StoreDatenSignal = 1'b0;
    BefehlAdresse = '0; DatenAdresse = '0; StoreDaten = '0;
    MemLeseDaten = '0; MemBereit = 1'b0;
    tick();
    do_reset();

    // Fetch with 3 wait cycles; request stays high through FERTIG.
    run_txn(K_BEFEHL, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    tick();
    chk1("no_refetch", MemAnfrage, 1'b0);

    // Load and fetch pending while a zero-wait store wins, then load, then fetch.
    LoadBefehlSignal = 1'b1; BefehlAdresse = 32'h104;
    LoadDatenSignal  = 1'b1;
    run_txn(K_SPEICHERN, 32'h2000, 32'h12345678, 32'h0, 0, 1'b0);
    run_txn(K_LADEN, 32'h300, 32'h0, 32'h0BADF00D, 0, 1'b0);
    run_txn(K_BEFEHL, 32'h104, 32'h0, 32'hCAFEF00D, 1, 1'b0);

    // Randomised data over a few ordinary transactions.
    for (int j = 0; j < 3; j++) begin
      r = $urandom;
      run_txn(K_LADEN, 32'h1000 + 32'(j * 4), 32'h0, r, $urandom_range(0, 2), 1'b0);
      run_txn(K_SPEICHERN, 32'h3000 + 32'(j * 4), $urandom, 32'h0, $urandom_range(0, 3), 1'b0);
    end

    // Load timeout, then Fehler must stay set across idle cycles and a good fetch.
    run_txn(K_LADEN, 32'h400, 32'h0, 32'h0, 0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk1("fehler_sticky", Fehler, 1'b1);
    end
    run_txn(K_BEFEHL, 32'h108, 32'h0, 32'h11112222, 0, 1'b0);

    // Only reset clears Fehler; MemBereit in the expiry cycle wins.
    do_reset();
    run_txn(K_LADEN, 32'h404, 32'h0, 32'hA5, 3, 1'b0);

    // Reset in the second ANFRAGE cycle of a fetch; late MemBereit ignored.
    run_txn(K_BEFEHL, 32'h600, 32'h0, 32'h77, 0, 1'b0);
    LoadBefehlSignal = 1'b1; BefehlAdresse = 32'h500;
    tick();
    chk1("rst_mid_anfrage1", MemAnfrage, 1'b1);
    tick();
    chk1("rst_mid_anfrage2", MemAnfrage, 1'b1);
    do_reset();
    MemBereit = 1'b1;
    MemLeseDaten = 32'h99;
    tick();
    MemBereit = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk1("late_bereit_no_pulse", BefehlGeladen | DatenGeladen | DatenGespeichert, 1'b0);
      chk1("late_bereit_idle", zustand_o === ST_IDLE, 1'b1);
      chk32("late_bereit_befehl", Befehl, 32'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
